// File: rtl/pipeline_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_defs : register-write source codes and the zero-register index
// Rev 1.0
// ---------------------------------------------------------------------------
package pipeline_defs;

  typedef enum logic [1:0] {
    REGSRC_ALU     = 2'd0,
    REGSRC_DMEM    = 2'd1,
    REGSRC_PCPLUS4 = 2'd2,
    REGSRC_RSVD    = 2'd3
  } regsrc_e;

  localparam int ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/operand_fwd_slice.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_fwd_slice : forwarding mux plus WB capture register for one operand
// Rev 1.0
// ---------------------------------------------------------------------------
module operand_fwd_slice
  import pipeline_defs::*;
#(
  parameter int DW   = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] src,
  input  logic [DW-1:0]   rf_data,
  input  logic            mem_regwrite,
  input  logic [1:0]      mem_regsrc,
  input  logic [RA_W-1:0] mem_writereg,
  input  logic [DW-1:0]   mem_alu_result,
  input  logic [DW-1:0]   mem_pc,
  input  logic            wb_regwrite,
  input  logic [RA_W-1:0] wb_writereg,
  input  logic [DW-1:0]   wb_wdata,
  output logic [DW-1:0]   opnd,
  output logic            mem_hit
);

  logic          wb_hit;
  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic          capture;

  assign mem_hit = mem_regwrite && (mem_writereg != RA_W'(ZERO_REG)) && (mem_writereg == src);
  assign wb_hit  = wb_regwrite  && (wb_writereg  != RA_W'(ZERO_REG)) && (wb_writereg  == src);

  // A MEM hit that will itself supply the operand makes the WB value stale.
  assign capture = ex_valid && wb_hit && !(mem_hit && (mem_regsrc != REGSRC_DMEM));

  always_comb begin
    opnd = rf_data;
    if (mem_hit && (mem_regsrc == REGSRC_ALU)) begin
      opnd = mem_alu_result;
    end else if (mem_hit && (mem_regsrc == REGSRC_PCPLUS4)) begin
      opnd = mem_pc + DW'(4);
    end else if (wb_hit) begin
      opnd = wb_wdata;
    end else if (cap_valid) begin
      opnd = cap_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cap_valid <= 1'b0;
    end else if (capture) begin
      cap_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!(rst || clear) && capture) begin
      cap_data <= wb_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/operand_bypass_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_bypass_unit : EX-stage operand forwarding, load-use stall, stall count
// Rev 1.0
// ---------------------------------------------------------------------------
module operand_bypass_unit
  import pipeline_defs::*;
#(
  parameter int DW    = 32,
  parameter int RA_W  = 5,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid,
  input  logic                 ex_hold,
  input  logic                 ex_flush,
  input  logic [NSRC*RA_W-1:0] ex_src,
  input  logic [NSRC-1:0]      ex_src_used,
  input  logic [NSRC*DW-1:0]   ex_rf_data,
  input  logic                 mem_regwrite,
  input  logic [1:0]           mem_regsrc,
  input  logic [RA_W-1:0]      mem_writereg,
  input  logic [DW-1:0]        mem_alu_result,
  input  logic [DW-1:0]        mem_pc,
  input  logic                 wb_regwrite,
  input  logic [RA_W-1:0]      wb_writereg,
  input  logic [DW-1:0]        wb_wdata,
  output logic [NSRC*DW-1:0]   ex_opnd,
  output logic                 stall_req,
  output logic [CNT_W-1:0]     stall_cnt
);

  logic [NSRC-1:0] mem_hit;
  logic            advance;
  logic            clear;

  assign stall_req = ex_valid && (mem_regsrc == REGSRC_DMEM) && (|(mem_hit & ex_src_used));
  assign advance   = ex_valid && !stall_req && !ex_hold;
  assign clear     = ex_flush || advance;

  for (genvar i = 0; i < NSRC; i++) begin : g_slice
    operand_fwd_slice #(
      .DW   (DW),
      .RA_W (RA_W)
    ) u_slice (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .ex_valid       (ex_valid),
      .src            (ex_src[i*RA_W +: RA_W]),
      .rf_data        (ex_rf_data[i*DW +: DW]),
      .mem_regwrite   (mem_regwrite),
      .mem_regsrc     (mem_regsrc),
      .mem_writereg   (mem_writereg),
      .mem_alu_result (mem_alu_result),
      .mem_pc         (mem_pc),
      .wb_regwrite    (wb_regwrite),
      .wb_writereg    (wb_writereg),
      .wb_wdata       (wb_wdata),
      .opnd           (ex_opnd[i*DW +: DW]),
      .mem_hit        (mem_hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_req && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_bypass_unit.sv
`default_nettype none
// Testbench for operand_bypass_unit: directed table, corner sequences, random vs model.
module tb_operand_bypass_unit;
  import pipeline_defs::*;

  localparam int DW = 32;
  localparam int RA_W = 5;
  localparam int NSRC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ex_valid, ex_hold, ex_flush;
  logic [NSRC*RA_W-1:0] ex_src;
  logic [NSRC-1:0] ex_src_used;
  logic [NSRC*DW-1:0] ex_rf_data;
  logic mem_regwrite;
  logic [1:0] mem_regsrc;
  logic [RA_W-1:0] mem_writereg;
  logic [DW-1:0] mem_alu_result, mem_pc;
  logic wb_regwrite;
  logic [RA_W-1:0] wb_writereg;
  logic [DW-1:0] wb_wdata;
  logic [NSRC*DW-1:0] ex_opnd, ex_opnd_s;
  logic stall_req, stall_req_s;
  logic [15:0] stall_cnt;
  logic [1:0] stall_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_bypass_unit #(.DW(DW), .RA_W(RA_W), .NSRC(NSRC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .ex_src(ex_src), .ex_src_used(ex_src_used), .ex_rf_data(ex_rf_data),
    .mem_regwrite(mem_regwrite), .mem_regsrc(mem_regsrc), .mem_writereg(mem_writereg),
    .mem_alu_result(mem_alu_result), .mem_pc(mem_pc), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_wdata(wb_wdata), .ex_opnd(ex_opnd),
    .stall_req(stall_req), .stall_cnt(stall_cnt));

  operand_bypass_unit #(.DW(DW), .RA_W(RA_W), .NSRC(NSRC), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_hold(ex_hold), .ex_flush(ex_flush),
    .ex_src(ex_src), .ex_src_used(ex_src_used), .ex_rf_data(ex_rf_data),
    .mem_regwrite(mem_regwrite), .mem_regsrc(mem_regsrc), .mem_writereg(mem_writereg),
    .mem_alu_result(mem_alu_result), .mem_pc(mem_pc), .wb_regwrite(wb_regwrite),
    .wb_writereg(wb_writereg), .wb_wdata(wb_wdata), .ex_opnd(ex_opnd_s),
    .stall_req(stall_req_s), .stall_cnt(stall_cnt_s));

  // ---------------- reference model ----------------
  logic          m_cv[NSRC];
  logic [DW-1:0] m_cd[NSRC];
  int unsigned   m_cnt = 0;
  int unsigned   m_cnt2 = 0;

  function automatic logic [RA_W-1:0] src_of(int i);
    return ex_src[i*RA_W +: RA_W];
  endfunction

  function automatic bit m_mem_hit(int i);
    return mem_regwrite && mem_writereg != 0 && mem_writereg == src_of(i);
  endfunction

  function automatic bit m_wb_hit(int i);
    return wb_regwrite && wb_writereg != 0 && wb_writereg == src_of(i);
  endfunction

  function automatic logic [DW-1:0] exp_opnd(int i);
    if (m_mem_hit(i) && mem_regsrc == 2'd0) return mem_alu_result;
    if (m_mem_hit(i) && mem_regsrc == 2'd2) return DW'((64'(mem_pc) + 64'd4) % 64'h1_0000_0000);
    if (m_wb_hit(i)) return wb_wdata;
    if (m_cv[i]) return m_cd[i];
    return ex_rf_data[i*DW +: DW];
  endfunction

  function automatic bit exp_stall();
    bit s = 0;
    for (int i = 0; i < NSRC; i++)
      if (ex_valid && mem_regsrc == 2'd1 && m_mem_hit(i) && ex_src_used[i]) s = 1;
    return s;
  endfunction

  task automatic model_update();
    bit st, adv;
    st  = exp_stall();
    adv = ex_valid && !st && !ex_hold;
    for (int i = 0; i < NSRC; i++) begin
      if (rst || ex_flush || adv) m_cv[i] = 0;
      else if (ex_valid && m_wb_hit(i) && !(m_mem_hit(i) && mem_regsrc != 2'd1)) begin
        m_cv[i] = 1;
        m_cd[i] = wb_wdata;
      end
    end
    if (rst) begin
      m_cnt = 0;
      m_cnt2 = 0;
    end else if (st) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < NSRC; i++) begin
      chk($sformatf("opnd%0d", i), 64'(ex_opnd[i*DW +: DW]), 64'(exp_opnd(i)));
      chk($sformatf("opnd%0d_small", i), 64'(ex_opnd_s[i*DW +: DW]), 64'(exp_opnd(i)));
    end
    chk("stall_req", 64'(stall_req), 64'(exp_stall()));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    chk("stall_cnt_small", 64'(stall_cnt_s), 64'(m_cnt2));
  endtask

  task automatic tick_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    tick_edge();
  endtask

  task automatic idle();
    ex_valid = 1; ex_hold = 0; ex_flush = 0;
    ex_src = '0; ex_src_used = '1; ex_rf_data = '0;
    mem_regwrite = 0; mem_regsrc = 2'd0; mem_writereg = '0;
    mem_alu_result = '0; mem_pc = '0;
    wb_regwrite = 0; wb_writereg = '0; wb_wdata = '0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v; logic mrw; logic [1:0] mrs; logic [4:0] mwr; logic [31:0] malu, mpc;
    logic wrw; logic [4:0] wwr; logic [31:0] wd;
    logic [4:0] s0, s1; logic [1:0] used; logic [31:0] rf0, rf1;
    logic [31:0] e0, e1; logic est;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, REGSRC_ALU,     5'd8,  32'h1234, 32'h0,        1'b0, 5'd0, 32'h0,  5'd8, 5'd3,  2'b11, 32'hDEAD, 32'h33, 32'h1234, 32'h33, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, REGSRC_PCPLUS4, 5'd31, 32'h0,    32'hFFFFFFFC, 1'b0, 5'd0, 32'h0,  5'd1, 5'd31, 2'b11, 32'h11,   32'h31, 32'h11,   32'h0,  1'b0};
    tbl[2]  = '{1'b1, 1'b1, REGSRC_DMEM,    5'd9,  32'hAAAA, 32'h0,        1'b0, 5'd0, 32'h0,  5'd2, 5'd9,  2'b11, 32'h22,   32'h99, 32'h22,   32'h99, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, REGSRC_DMEM,    5'd9,  32'hAAAA, 32'h0,        1'b0, 5'd0, 32'h0,  5'd2, 5'd9,  2'b01, 32'h22,   32'h99, 32'h22,   32'h99, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, REGSRC_ALU,     5'd0,  32'h77,   32'h0,        1'b1, 5'd0, 32'h88, 5'd0, 5'd0,  2'b11, 32'hA0,   32'hA1, 32'hA0,   32'hA1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, REGSRC_DMEM,    5'd0,  32'h77,   32'h0,        1'b0, 5'd0, 32'h0,  5'd0, 5'd0,  2'b11, 32'hA0,   32'hA1, 32'hA0,   32'hA1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, REGSRC_ALU,     5'd5,  32'h50,   32'h0,        1'b1, 5'd5, 32'h60, 5'd5, 5'd5,  2'b11, 32'h1,    32'h2,  32'h50,   32'h50, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, REGSRC_DMEM,    5'd5,  32'h50,   32'h0,        1'b1, 5'd5, 32'h60, 5'd5, 5'd5,  2'b01, 32'h1,    32'h2,  32'h60,   32'h60, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, REGSRC_RSVD,    5'd6,  32'h1,    32'h0,        1'b1, 5'd6, 32'h66, 5'd6, 5'd4,  2'b11, 32'h1,    32'h4,  32'h66,   32'h4,  1'b0};
    tbl[9]  = '{1'b0, 1'b1, REGSRC_DMEM,    5'd9,  32'h0,    32'h0,        1'b0, 5'd0, 32'h0,  5'd9, 5'd9,  2'b11, 32'h90,   32'h91, 32'h90,   32'h91, 1'b0};
    tbl[10] = '{1'b1, 1'b1, REGSRC_PCPLUS4, 5'd7,  32'h0,    32'h100,      1'b0, 5'd0, 32'h0,  5'd7, 5'd7,  2'b00, 32'h5,    32'h6,  32'h104,  32'h104, 1'b0};
  end

  initial begin
    for (int i = 0; i < NSRC; i++) begin m_cv[i] = 0; m_cd[i] = '0; end
    idle();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    rst = 0;

    // Directed combinational table, applied under reset so no state carries over.
    for (int k = 0; k < 11; k++) begin
      rst = 1;
      ex_valid = tbl[k].v; ex_hold = 0; ex_flush = 0;
      mem_regwrite = tbl[k].mrw; mem_regsrc = tbl[k].mrs; mem_writereg = tbl[k].mwr;
      mem_alu_result = tbl[k].malu; mem_pc = tbl[k].mpc;
      wb_regwrite = tbl[k].wrw; wb_writereg = tbl[k].wwr; wb_wdata = tbl[k].wd;
      ex_src = {tbl[k].s1, tbl[k].s0}; ex_src_used = tbl[k].used;
      ex_rf_data = {tbl[k].rf1, tbl[k].rf0};
      @(negedge clk);
      chk($sformatf("tbl%0d_opnd0", k), 64'(ex_opnd[31:0]), 64'(tbl[k].e0));
      chk($sformatf("tbl%0d_opnd1", k), 64'(ex_opnd[63:32]), 64'(tbl[k].e1));
      chk($sformatf("tbl%0d_stall", k), 64'(stall_req), 64'(tbl[k].est));
      tick_edge();
    end
    rst = 0;
    idle();
    cycle();

    // Load-use: stall one cycle, then the WB path serves the loaded value.
    mem_regwrite = 1; mem_regsrc = REGSRC_DMEM; mem_writereg = 9;
    ex_src = {5'd9, 5'd2};
    cycle();
    idle(); ex_src = {5'd9, 5'd2};
    wb_regwrite = 1; wb_writereg = 9; wb_wdata = 32'hCAFE;
    @(negedge clk);
    model_check();
    chk("lu_opnd1", 64'(ex_opnd[63:32]), 64'h0000CAFE);
    chk("lu_cnt", 64'(stall_cnt), 64'd1);
    tick_edge();

    // Freeze for three cycles with a WB capture in the first.
    idle(); ex_hold = 1; ex_src = {5'd0, 5'd4};
    wb_regwrite = 1; wb_writereg = 4; wb_wdata = 32'h55;
    cycle();
    wb_regwrite = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      model_check();
      chk("hold_opnd0", 64'(ex_opnd[31:0]), 64'h55);
      tick_edge();
    end
    ex_hold = 0;
    cycle();
    @(negedge clk);
    chk("release_opnd0", 64'(ex_opnd[31:0]), 64'h0);
    tick_edge();

    // Same freeze with a flush in the second cycle.
    idle(); ex_hold = 1; ex_src = {5'd0, 5'd4}; ex_rf_data = {32'h0, 32'hAB};
    wb_regwrite = 1; wb_writereg = 4; wb_wdata = 32'h55;
    cycle();
    wb_regwrite = 0; ex_flush = 1;
    cycle();
    ex_flush = 0;
    @(negedge clk);
    model_check();
    chk("flush_opnd0", 64'(ex_opnd[31:0]), 64'hAB);
    tick_edge();

    // Flush and capture in the same cycle: flush wins.
    wb_regwrite = 1; ex_flush = 1;
    cycle();
    wb_regwrite = 0; ex_flush = 0;
    @(negedge clk);
    chk("flush_vs_cap", 64'(ex_opnd[31:0]), 64'hAB);
    tick_edge();

    // Reset mid-freeze drops the capture.
    wb_regwrite = 1;
    cycle();
    wb_regwrite = 0; rst = 1;
    cycle();
    rst = 0;
    @(negedge clk);
    chk("rst_drop_cap", 64'(ex_opnd[31:0]), 64'hAB);
    tick_edge();

    // Saturation of the 2-bit counter, then reset.
    idle(); rst = 1; cycle(); rst = 0;
    mem_regwrite = 1; mem_regsrc = REGSRC_DMEM; mem_writereg = 3; ex_src = {5'd3, 5'd3};
    for (int c = 0; c < 5; c++) cycle();
    idle();
    @(negedge clk);
    chk("sat_cnt_small", 64'(stall_cnt_s), 64'd3);
    chk("sat_cnt_wide", 64'(stall_cnt), 64'd5);
    tick_edge();
    rst = 1;
    cycle();
    rst = 0;
    @(negedge clk);
    chk("sat_cnt_rst", 64'(stall_cnt_s), 64'd0);
    tick_edge();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      ex_valid = ($urandom_range(0, 7) != 0);
      ex_hold = ($urandom_range(0, 2) == 0);
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_src_used = 2'($urandom_range(0, 3));
      ex_rf_data = {$urandom, $urandom};
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_regsrc = 2'($urandom_range(0, 3));
      mem_writereg = 5'($urandom_range(0, 7));
      mem_alu_result = $urandom;
      mem_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_writereg = 5'($urandom_range(0, 7));
      wb_wdata = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
